// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer.
//   - ALU_DATA_W / ALU_OP_W : operand and opcode widths
//   - ALU_* opcode constants (6 and 7 are illegal)
//   - alu_cmd_t : packed {a, b, op} command payload
//   - slot_state_t : result-slot state encoding
package alu_pkg;

    localparam int unsigned ALU_DATA_W = 8;
    localparam int unsigned ALU_OP_W   = 3;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'd1;
    localparam logic [ALU_OP_W-1:0] ALU_MAX = 3'd2;
    localparam logic [ALU_OP_W-1:0] ALU_MIN = 3'd3;
    localparam logic [ALU_OP_W-1:0] ALU_SHR = 3'd4;
    localparam logic [ALU_OP_W-1:0] ALU_SHL = 3'd5;

    typedef struct packed {
        logic [ALU_DATA_W-1:0] a;
        logic [ALU_DATA_W-1:0] b;
        logic [ALU_OP_W-1:0]   op;
    } alu_cmd_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // Opcodes above ALU_SHL have no ALU function.
    function automatic logic op_illegal(input logic [ALU_OP_W-1:0] op);
        return op > ALU_SHL;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous DEPTH-entry FIFO holding alu_cmd_t commands.
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   push, push_cmd    : write request (ignored when full) and payload
//   pop               : read request (ignored when empty)
//   head              : entry at the read pointer (undefined when empty)
//   full, empty, count: occupancy status, count in 0..DEPTH
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  alu_cmd_t                 push_cmd,
    input  logic                     pop,
    output alu_cmd_t                 head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    alu_cmd_t          mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt_q;
    logic              do_push;
    logic              do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;
    assign head  = mem[rd_ptr];

    // Storage needs no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_cmd;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command-issue / result-capture stage around an external combinational ALU.
// Commands are queued in alu_cmd_fifo, the head drives the ALU, and the ALU
// output is captured into a single result slot drained over valid/ready.
// Optional feature: define ALU_SEQ_OVF_CNT_EN to build the saturating
// overflow counter; otherwise ovf_cnt is tied to zero and ovf_clr is unused.
// Ports:
//   clk, rst_n                         : clock, async active-low reset
//   cmd_valid/cmd_ready, cmd_a/b/op    : command input handshake
//   alu_a/b/op (out), alu_z/of (in)    : external ALU connection
//   res_valid/res_ready, res_z/of/op/err : result output handshake
//   busy                               : commands queued or result held
//   ovf_clr, ovf_cnt                   : overflow counter clear / value
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = ALU_DATA_W,
    parameter int unsigned OP_W   = ALU_OP_W,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [OP_W-1:0]   cmd_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_z,
    input  logic              alu_of,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_z,
    output logic              res_of,
    output logic [OP_W-1:0]   res_op,
    output logic              res_err,
    output logic              busy,
    input  logic              ovf_clr,
    output logic [7:0]        ovf_cnt
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    alu_cmd_t          push_cmd;
    alu_cmd_t          head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              issue;
    logic              head_bad;

    slot_state_t       state_q;
    slot_state_t       state_d;
    logic [DATA_W-1:0] res_z_d;
    logic              res_of_d;
    logic [OP_W-1:0]   res_op_d;
    logic              res_err_d;

    assign push_cmd = '{a: cmd_a, b: cmd_b, op: cmd_op};

    alu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (cmd_valid),
        .push_cmd (push_cmd),
        .pop      (issue),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // No bypass: every command passes through the FIFO.
    assign cmd_ready = ~fifo_full;

    // ALU sees the FIFO head, or zeros when nothing is queued.
    assign alu_a  = fifo_empty ? '0 : head.a;
    assign alu_b  = fifo_empty ? '0 : head.b;
    assign alu_op = fifo_empty ? '0 : head.op;

    assign head_bad  = op_illegal(head.op);
    assign res_valid = (state_q == SLOT_FULL);
    assign busy      = (fifo_count != '0) | res_valid;

    // Result-slot state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Issue decision, slot next-state and next result fields.
    always_comb begin
        state_d   = state_q;
        res_z_d   = res_z;
        res_of_d  = res_of;
        res_op_d  = res_op;
        res_err_d = res_err;
        issue     = ~fifo_empty & ((state_q == SLOT_EMPTY) | res_ready);

        case (state_q)
            SLOT_EMPTY: if (issue) state_d = SLOT_FULL;
            SLOT_FULL:  if (!issue && res_ready) state_d = SLOT_EMPTY;
            default:    state_d = SLOT_EMPTY;
        endcase

        if (issue) begin
            res_op_d = head.op;
            if (head_bad) begin
                res_z_d   = '0;
                res_of_d  = 1'b0;
                res_err_d = 1'b1;
            end else begin
                res_z_d   = alu_z;
                res_of_d  = alu_of;
                res_err_d = 1'b0;
            end
        end
    end

    // Result data registers; hold their value after a plain drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_z   <= '0;
            res_of  <= 1'b0;
            res_op  <= '0;
            res_err <= 1'b0;
        end else begin
            res_z   <= res_z_d;
            res_of  <= res_of_d;
            res_op  <= res_op_d;
            res_err <= res_err_d;
        end
    end

`ifdef ALU_SEQ_OVF_CNT_EN
    logic [7:0] ovf_cnt_q;

    // Saturating count of legal issues that overflowed; clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt_q <= 8'd0;
        end else if (ovf_clr) begin
            ovf_cnt_q <= 8'd0;
        end else if (issue && !head_bad && alu_of && (ovf_cnt_q != 8'hFF)) begin
            ovf_cnt_q <= ovf_cnt_q + 8'd1;
        end
    end

    assign ovf_cnt = ovf_cnt_q;
`else
    logic unused_ovf_clr;

    assign unused_ovf_clr = ovf_clr;
    assign ovf_cnt        = 8'd0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural ALU model.
module tb_alu_op_sequencer;

`ifdef ALU_SEQ_OVF_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [2:0] cmd_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_op;
    logic [7:0] alu_z;
    logic       alu_of;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_z;
    logic       res_of;
    logic [2:0] res_op;
    logic       res_err;
    logic       busy;
    logic       ovf_clr;
    logic [7:0] ovf_cnt;

    typedef struct packed {
        logic [7:0] z;
        logic       of;
        logic [2:0] op;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    alu_op_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_op    (cmd_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_z     (alu_z),
        .alu_of    (alu_of),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_z     (res_z),
        .res_of    (res_of),
        .res_op    (res_op),
        .res_err   (res_err),
        .busy      (busy),
        .ovf_clr   (ovf_clr),
        .ovf_cnt   (ovf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU model; illegal opcodes return junk to expose missing masking.
    always_comb begin
        alu_z  = 8'h00;
        alu_of = 1'b0;
        case (alu_op)
            3'd0: begin
                alu_z  = alu_a + alu_b;
                alu_of = (alu_a[7] == alu_b[7]) && (alu_z[7] != alu_a[7]);
            end
            3'd1: begin
                alu_z  = alu_a - alu_b;
                alu_of = (alu_a[7] != alu_b[7]) && (alu_z[7] != alu_a[7]);
            end
            3'd2: alu_z = ($signed(alu_a) > $signed(alu_b)) ? alu_a : alu_b;
            3'd3: alu_z = ($signed(alu_a) < $signed(alu_b)) ? alu_a : alu_b;
            3'd4: alu_z = 8'($signed(alu_a) >>> 1);
            3'd5: begin
                alu_z  = alu_b << 1;
                alu_of = alu_b[7] ^ alu_b[6];
            end
            default: begin
                alu_z  = 8'hAA;
                alu_of = 1'b1;
            end
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
        end
    endtask

    // Monitor: every accepted result is compared against the queue head.
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got z=0x%0h op=%0d expected none", res_z, res_op);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("res_z", 32'(res_z), 32'(e.z));
                chk("res_of", 32'(res_of), 32'(e.of));
                chk("res_op", 32'(res_op), 32'(e.op));
                chk("res_err", 32'(res_err), 32'(e.err));
            end
        end
    end

    // Drive one command (called at posedge+1) and queue its expected result.
    task automatic send(input int a, input int b, input int op,
                        input int ez, input bit eof, input bit eerr);
        int n;
        exp_t e;
        cmd_valid = 1'b1;
        cmd_a     = 8'(a);
        cmd_b     = 8'(b);
        cmd_op    = 3'(op);
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got cmd_ready=0 expected 1");
        end else begin
            e.z   = 8'(ez);
            e.of  = eof;
            e.op  = 3'(op);
            e.err = eerr;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: got busy=1 expected 0");
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] held_z;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_a     = 8'd0;
        cmd_b     = 8'd0;
        cmd_op    = 3'd0;
        res_ready = 1'b1;
        ovf_clr   = 1'b0;

        // Reset state.
        #3;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_res_z", 32'(res_z), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
        #9;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single add with latency check.
        send(2, 3, 0, 5, 1'b0, 1'b0);
        @(negedge clk);
        chk("lat_n_valid", 32'(res_valid), 32'd0);
        chk("lat_n_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("lat_n1_valid", 32'(res_valid), 32'd1);
        @(posedge clk);
        #1;
        wait_idle();

        // Back-to-back overflowing add/add/sub.
        send(64, 64, 0, -128, 1'b1, 1'b0);
        send(-60, -75, 0, 121, 1'b1, 1'b0);
        send(-100, 50, 1, 106, 1'b1, 1'b0);
        wait_idle();
        chk("ovf_cnt_3", 32'(ovf_cnt), CNT_EN ? 32'd3 : 32'd0);

        // Backpressure: capacity is FIFO depth plus the result slot.
        res_ready = 1'b0;
        send(1, 1, 0, 2, 1'b0, 1'b0);
        send(10, 3, 1, 7, 1'b0, 1'b0);
        send(-5, 4, 2, 4, 1'b0, 1'b0);
        send(-8, 0, 4, -4, 1'b0, 1'b0);
        send(0, 80, 5, 8'hA0, 1'b1, 1'b0);
        cmd_valid = 1'b1;
        cmd_a     = 8'd9;
        cmd_b     = 8'd9;
        cmd_op    = 3'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("bp_res_valid", 32'(res_valid), 32'd1);
            if (i == 0) held_z = res_z;
            else chk("bp_res_z_stable", 32'(res_z), 32'(held_z));
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_stream_valid", 32'(res_valid), 32'd1);
        end
        @(negedge clk);
        chk("bp_stream_end", 32'(res_valid), 32'd0);
        @(posedge clk);
        #1;
        wait_idle();

        // Illegal opcode followed by a legal max.
        send(7, 3, 6, 0, 1'b0, 1'b1);
        send(12, 28, 2, 28, 1'b0, 1'b0);
        wait_idle();

        // Counter saturation, then clear racing an overflow.
        for (int i = 0; i < 300; i++) begin
            send(64, 64, 0, -128, 1'b1, 1'b0);
        end
        wait_idle();
        chk("ovf_cnt_sat", 32'(ovf_cnt), CNT_EN ? 32'd255 : 32'd0);
        ovf_clr = 1'b1;
        send(64, 64, 0, -128, 1'b1, 1'b0);
        wait_idle();
        ovf_clr = 1'b0;
        chk("ovf_cnt_clr", 32'(ovf_cnt), 32'd0);
        send(-100, 50, 1, 106, 1'b1, 1'b0);
        wait_idle();
        chk("ovf_cnt_after_clr", 32'(ovf_cnt), CNT_EN ? 32'd1 : 32'd0);

        // Asynchronous reset with one held and three queued.
        res_ready = 1'b0;
        send(1, 2, 0, 3, 1'b0, 1'b0);
        send(3, 4, 0, 7, 1'b0, 1'b0);
        send(5, 6, 0, 11, 1'b0, 1'b0);
        send(7, 8, 0, 15, 1'b0, 1'b0);
        @(negedge clk);
        chk("pre_rst_valid", 32'(res_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_valid", 32'(res_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("mid_rst_alu_a", 32'(alu_a), 32'd0);
        #3;
        rst_n     = 1'b1;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        send(-5, 4, 3, -5, 1'b0, 1'b0);
        @(negedge clk);
        chk("post_rst_lat_n", 32'(res_valid), 32'd0);
        @(negedge clk);
        chk("post_rst_lat_n1", 32'(res_valid), 32'd1);
        @(posedge clk);
        #1;
        wait_idle();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
